// File: rtl/iterative_divider_pkg.sv
// rtl/iterative_divider_pkg.sv - shared types and constants for the iterative divider
//
// Holds the operand width, the opcode and FSM state encodings, the signed
// overflow constants and a conditional two's-complement negate helper.

package iterative_divider_pkg;

  localparam int XLEN  = 32;
  localparam int OP_W  = 2;
  localparam int CNT_W = $clog2(XLEN);

  // Bit 0 set means unsigned; bit 1 set means the remainder is returned.
  typedef enum logic [OP_W-1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] value,
                                               input logic            neg);
    return neg ? (~value + {{(XLEN-1){1'b0}}, 1'b1}) : value;
  endfunction

endpackage

// File: rtl/iterative_divider_div_step_unit.sv
// rtl/iterative_divider_div_step_unit.sv - one radix-2 restoring shift-subtract step
//
// Ports:
//   rem       current partial remainder
//   quo       current quotient / remaining dividend bits
//   divisor   unsigned divisor magnitude
//   rem_next  partial remainder after this step
//   quo_next  quotient after this step (new bit shifted into bit 0)

module iterative_divider_div_step_unit
  import iterative_divider_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  // The shifted remainder needs one extra bit: rem < divisor <= 2^XLEN-1,
  // so after the shift it can exceed XLEN bits. The trial's top bit is then
  // a reliable borrow flag.
  logic [XLEN:0] rem_shifted;
  logic [XLEN:0] trial;

  always_comb begin
    rem_shifted = {rem, quo[XLEN-1]};
    trial       = rem_shifted - {1'b0, divisor};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = rem_shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit
//
// Ports:
//   clk_i           clock, rising edge
//   rst             asynchronous reset, active-low
//   req_valid_i     request present
//   req_ready_o     unit can accept a request (IDLE)
//   req_op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_dividend_i  rs1 value
//   req_divisor_i   rs2 value
//   kill_i          pipeline flush; abandons any operation, no response
//   resp_valid_o    result available (DONE)
//   resp_ready_i    consumer takes result
//   resp_result_o   quotient or remainder, held stable while in DONE
//   busy_o          state is not IDLE

module iterative_divider
  import iterative_divider_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [OP_W-1:0] req_op_i,
  input  logic [XLEN-1:0] req_dividend_i,
  input  logic [XLEN-1:0] req_divisor_i,
  input  logic            kill_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o,
  output logic            busy_o
);

  div_state_e       state;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  result_q;

  // Request decode, only meaningful in the accept cycle.
  logic            req_signed;
  logic            req_is_rem;
  logic            dividend_neg;
  logic            divisor_neg;
  logic [XLEN-1:0] dividend_abs;
  logic [XLEN-1:0] divisor_abs;
  logic            div_by_zero;
  logic            signed_ovf;

  always_comb begin
    req_signed   = ~req_op_i[0];
    req_is_rem   = req_op_i[1];
    dividend_neg = req_signed & req_dividend_i[XLEN-1];
    divisor_neg  = req_signed & req_divisor_i[XLEN-1];
    dividend_abs = cond_neg(req_dividend_i, dividend_neg);
    divisor_abs  = cond_neg(req_divisor_i, divisor_neg);
    div_by_zero  = (req_divisor_i == '0);
    signed_ovf   = req_signed && (req_dividend_i == INT_MIN) &&
                   (req_divisor_i == ALL_ONES);
  end

  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;

  iterative_divider_div_step_unit u_div_step_unit (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else if (kill_i) begin
      // Flush wins over accept and over a same-cycle response handshake.
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            is_rem_q  <= req_is_rem;
            neg_quo_q <= dividend_neg ^ divisor_neg;
            neg_rem_q <= dividend_neg;
            divisor_q <= divisor_abs;
            cnt_q     <= CNT_W'(XLEN-1);
            if (div_by_zero) begin
              result_q <= req_is_rem ? req_dividend_i : ALL_ONES;
              state    <= S_DONE;
            end else if (signed_ovf) begin
              result_q <= req_is_rem ? '0 : INT_MIN;
              state    <= S_DONE;
            end else begin
              rem_q <= '0;
              quo_q <= dividend_abs;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q == '0) begin
            // Sign fix is taken straight from the final step's outputs.
            result_q <= is_rem_q ? cond_neg(rem_next, neg_rem_q)
                                 : cond_neg(quo_next, neg_quo_q);
            state    <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (resp_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state == S_IDLE);
  assign busy_o        = (state != S_IDLE);
  assign resp_valid_o  = (state == S_DONE);
  assign resp_result_o = result_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - directed self-checking bench for iterative_divider

module tb_iterative_divider;
  import iterative_divider_pkg::*;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic [XLEN-1:0] req_dividend;
  logic [XLEN-1:0] req_divisor;
  logic            kill;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  iterative_divider dut (
    .clk_i          (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_op_i       (req_op),
    .req_dividend_i (req_dividend),
    .req_divisor_i  (req_divisor),
    .kill_i         (kill),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_result_o  (resp_result),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_result"},     resp_result,     32'd0);
    chk({tag, "_busy"},       32'(busy),       32'd0);
  endtask

  // Called #1 after a posedge with the unit idle and resp_ready high.
  // Latency counts edges from the accept edge (1) to the edge after which
  // resp_valid is first seen.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit seen;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    req_valid    = 1'b1;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat++;
      if (resp_valid) seen = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, resp_result, exp_res);
    @(posedge clk);
    #1;
    chk({tag, "_idle_after"}, 32'({busy, resp_valid, req_ready}), 32'b001);
  endtask

  initial begin
    bit seen;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_op       = '0;
    req_dividend = '0;
    req_divisor  = '0;
    kill         = 1'b0;
    resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2,  33);

    run_op("div_m7_2",  DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",  DIV_OP_REM, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33);
    run_op("div_7_m2",  DIV_OP_DIV, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 33);
    run_op("div_min_3", DIV_OP_DIV, 32'h8000_0000, 32'd3,          32'hD555_5556, 33);
    run_op("rem_min_3", DIV_OP_REM, 32'h8000_0000, 32'd3,          32'hFFFF_FFFE, 33);

    run_op("div_by0",  DIV_OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("divu_by0", DIV_OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_by0",  DIV_OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("remu_by0", DIV_OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);

    run_op("div_ovf",  DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    run_op("divu_ovf", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33);

    // Response back-pressure: result held, no new request accepted.
    resp_ready   = 1'b0;
    req_op       = DIV_OP_DIVU;
    req_dividend = 32'd100;
    req_divisor  = 32'd7;
    req_valid    = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (resp_valid) seen = 1'b1;
    end
    chk("hold_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result",     resp_result,     32'd14);
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_req_ready",  32'(req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", 32'({busy, resp_valid, req_ready}), 32'b001);
    run_op("remu_1000_7", DIV_OP_REMU, 32'd1000, 32'd7, 32'd6, 33);

    // Kill in the tenth BUSY cycle.
    req_op       = DIV_OP_DIVU;
    req_dividend = 32'd1000;
    req_divisor  = 32'd3;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("kill_busy_before", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_state", 32'({busy, resp_valid, req_ready}), 32'b001);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    chk("kill_no_resp", 32'(seen), 32'd0);
    run_op("divu_1000_3", DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);

    // Asynchronous reset in the twentieth BUSY cycle, away from the clock edge.
    req_op       = DIV_OP_DIV;
    req_dividend = 32'hFFFF_FF9C;
    req_divisor  = 32'd7;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    chk_reset_outputs("mid_reset_held");
    rst = 1'b1;
    run_op("div_m100_7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("rem_m100_7", DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
